// File: rtl/hs_rx_deserializer.sv
// HS receive deserializer for one D-PHY data lane: SoT sync search at either bit alignment,
// then LSB-first byte assembly. Define RX_SOT_TOLERANT_EN to accept a sync byte with one bit error.
module hs_rx_deserializer #(
  parameter logic [7:0]  SYNC_WORD    = 8'hB8,
  parameter int unsigned SYNC_TIMEOUT = 16
) (
  input  logic       RxDDRClkHS,
  input  logic       RxRst,
  input  logic       des_en,
  input  logic       serial_B1,
  input  logic       serial_B2,
  output logic [7:0] RxByteHS,
  output logic       RxValidHS,
  output logic       RxActiveHS,
  output logic       RxSyncHS,
  output logic       ErrSotHS,
  output logic       ErrSotSyncHS
);

  localparam int unsigned          TimeoutW   = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [TimeoutW-1:0] TimeoutVal = TimeoutW'(SYNC_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSearch, StReceive, StErrWait} state_e;

  state_e              state_q, state_d;
  logic [7:0]          sr_q, sr_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [TimeoutW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]          byte_q, byte_d;
  logic                valid_q, valid_d;
  logic                active_q, active_d;
  logic                sync_q, sync_d;
  logic                err_sot_q, err_sot_d;
  logic                err_sync_q, err_sync_d;

  // B1 shifts in first, then B2; sr_b1 is also the odd sync window, sr_b2 the even one.
  logic [7:0] sr_b1, sr_b2;
  logic [2:0] cnt_b1, cnt_b2;
  logic       done_b1, done_b2;

  assign sr_b1   = {serial_B1, sr_q[7:1]};
  assign sr_b2   = {serial_B2, sr_b1[7:1]};
  assign done_b1 = (bit_cnt_q == 3'd7);
  assign cnt_b1  = bit_cnt_q + 3'd1;
  assign done_b2 = (cnt_b1 == 3'd7);
  assign cnt_b2  = cnt_b1 + 3'd1;

  logic exact_odd, exact_even, near_odd, near_even;
  logic match_odd, match_even, match_tol;

  assign exact_odd  = (sr_b1 == SYNC_WORD);
  assign exact_even = (sr_b2 == SYNC_WORD);

`ifdef RX_SOT_TOLERANT_EN
  assign near_odd  = ($countones(sr_b1 ^ SYNC_WORD) == 1);
  assign near_even = ($countones(sr_b2 ^ SYNC_WORD) == 1);
`else
  assign near_odd  = 1'b0;
  assign near_even = 1'b0;
`endif

  // Priority: exact odd, exact even, near odd, near even.
  assign match_odd  = exact_odd | (~exact_even & near_odd);
  assign match_even = ~match_odd & (exact_even | near_even);
  assign match_tol  = ~exact_odd & ~exact_even & (near_odd | near_even);

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    to_cnt_d   = to_cnt_q;
    byte_d     = byte_q;
    valid_d    = 1'b0;
    sync_d     = 1'b0;
    err_sot_d  = 1'b0;
    err_sync_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (des_en) begin
          state_d  = StSearch;
          sr_d     = '0;
          to_cnt_d = '0;
        end
      end
      StSearch: begin
        sr_d     = sr_b2;
        to_cnt_d = to_cnt_q + TimeoutW'(1);
        if (!des_en) begin
          state_d = StIdle;
        end else if (match_odd || match_even) begin
          state_d   = StReceive;
          sync_d    = 1'b1;
          err_sot_d = match_tol;
          // Odd alignment: B2 of this cycle is already bit0 of the first byte.
          bit_cnt_d = match_odd ? 3'd1 : 3'd0;
        end else if (to_cnt_d == TimeoutVal) begin
          state_d    = StErrWait;
          err_sync_d = 1'b1;
        end
      end
      StReceive: begin
        sr_d      = sr_b2;
        bit_cnt_d = cnt_b2;
        if (done_b1) begin
          valid_d = 1'b1;
          byte_d  = sr_b1;
        end else if (done_b2) begin
          valid_d = 1'b1;
          byte_d  = sr_b2;
        end
        if (!des_en) state_d = StIdle;
      end
      StErrWait: begin
        if (!des_en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    active_d = (state_d == StReceive);
  end

  always_ff @(posedge RxDDRClkHS) begin
    if (RxRst) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      to_cnt_q   <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
      sync_q     <= 1'b0;
      err_sot_q  <= 1'b0;
      err_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      to_cnt_q   <= to_cnt_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
      sync_q     <= sync_d;
      err_sot_q  <= err_sot_d;
      err_sync_q <= err_sync_d;
    end
  end

  assign RxByteHS     = byte_q;
  assign RxValidHS    = valid_q;
  assign RxActiveHS   = active_q;
  assign RxSyncHS     = sync_q;
  assign ErrSotHS     = err_sot_q;
  assign ErrSotSyncHS = err_sync_q;

endmodule
